// File: rtl/top.sv
// Registered ALU, accumulator, rotator, XOR pipe and cycle counter.
// Every output bit comes from a flop; rst_n is active-high and async.
module top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [134:0] in_flat,
  output logic [158:0] out_flat
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [31:0] d;
  logic [6:0]  ctrl;

  logic [2:0]  op;
  logic        acc_en;
  logic        acc_clr;
  logic [1:0]  rot_sel;

  assign a    = in_flat[31:0];
  assign b    = in_flat[63:32];
  assign c    = in_flat[95:64];
  assign d    = in_flat[127:96];
  assign ctrl = in_flat[134:128];

  assign op      = ctrl[2:0];
  assign acc_en  = ctrl[3];
  assign acc_clr = ctrl[4];
  assign rot_sel = ctrl[6:5];

  logic [32:0] sum;
  logic [31:0] alu_r;
  logic        alu_c;
  logic [32:0] acc_sum;
  logic [31:0] rot_d;
  logic [5:0]  pop_a;

  logic [31:0] r_q;
  logic        carry_q;
  logic        zero_q;
  logic        par_q;
  logic [31:0] acc_q;
  logic        ovf_q;
  logic [31:0] rot_q;
  logic [31:0] x1_q;
  logic [31:0] x2_q;
  logic [15:0] cnt_q;
  logic [5:0]  pop_q;
  logic [4:0]  echo_q;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign acc_sum = {1'b0, acc_q} + {1'b0, c};

  // ALU result and carry/borrow for the selected op
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (op)
      3'd0: begin
        alu_r = sum[31:0];
        alu_c = sum[32];
      end
      3'd1: begin
        alu_r = a - b;
        alu_c = (a < b);
      end
      3'd2: alu_r = a & b;
      3'd3: alu_r = a | b;
      3'd4: alu_r = a ^ b;
      3'd5: alu_r = a << b[4:0];
      3'd6: alu_r = a >> b[4:0];
      3'd7: alu_r = {31'd0, $signed(a) < $signed(b)};
      default: alu_r = '0;
    endcase
  end

  // Byte-granular left rotate of D
  always_comb begin
    rot_d = d;
    unique case (rot_sel)
      2'd0: rot_d = d;
      2'd1: rot_d = {d[23:0], d[31:24]};
      2'd2: rot_d = {d[15:0], d[31:16]};
      2'd3: rot_d = {d[7:0], d[31:8]};
      default: rot_d = d;
    endcase
  end

  // Population count of A
  always_comb begin
    pop_a = '0;
    for (int i = 0; i < 32; i++) begin
      pop_a = pop_a + {5'd0, a[i]};
    end
  end

  // ALU result and flag registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      r_q     <= alu_r;
      carry_q <= alu_c;
      zero_q  <= (alu_r == 32'd0);
      par_q   <= ^alu_r;
    end
  end

  // Accumulator with clear priority and sticky overflow
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_en) begin
      acc_q <= acc_sum[31:0];
      ovf_q <= ovf_q | acc_sum[32];
    end
  end

  // Rotate, two-stage C^D pipe, popcount and ctrl echo
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rot_q  <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      pop_q  <= '0;
      echo_q <= '0;
    end else begin
      rot_q  <= rot_d;
      x1_q   <= c ^ d;
      x2_q   <= x1_q;
      pop_q  <= pop_a;
      echo_q <= ctrl[4:0];
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_q + 16'd1;
  end

  assign out_flat = {echo_q, par_q, ovf_q, carry_q,
                     zero_q, pop_q, cnt_q, x2_q,
                     rot_q, acc_q, r_q};

endmodule

// File: tb/tb_top.sv
// Directed bench for top: hand-computed vectors.
// Inputs change 1ns after each rising edge.
module tb_top;

  logic         clk;
  logic         rst_n;
  logic [134:0] in_flat;
  logic [158:0] out_flat;

  int checks;
  int failures;

  top u_top (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [158:0] got,
                     input logic [158:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [134:0] mk(
    input logic [6:0]  ctrl,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d);
    return {ctrl, d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [158:0] snap;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    in_flat  = mk(7'h7f, 32'hdeadbeef, 32'h1234,
                  32'hffffffff, 32'h55aa55aa);

    // held reset: all zero every cycle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", out_flat, '0);
    end

    // release with quiet inputs; counter 1,2,3
    in_flat = '0;
    rst_n   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("cnt_run", out_flat[143:128], i);
    end

    // ALU vectors
    in_flat = mk(7'd0, 32'hffffffff, 32'd1, 0, 0);
    step();
    chk("add_r", out_flat[31:0], 0);
    chk("add_z", out_flat[150], 1);
    chk("add_c", out_flat[151], 1);
    chk("add_p", out_flat[153], 0);

    in_flat = mk(7'd1, 32'd0, 32'd1, 0, 0);
    step();
    chk("sub_r", out_flat[31:0], 32'hffffffff);
    chk("sub_c", out_flat[151], 1);
    chk("sub_p", out_flat[153], 0);
    chk("sub_z", out_flat[150], 0);

    in_flat = mk(7'd7, 32'h80000000, 32'd0, 0, 0);
    step();
    chk("slt_r", out_flat[31:0], 1);

    in_flat = mk(7'd5, 32'd1, 32'h24, 0, 0);
    step();
    chk("shl_r", out_flat[31:0], 32'h10);

    in_flat = mk(7'd6, 32'h80000000, 32'd31, 0, 0);
    step();
    chk("shr_r", out_flat[31:0], 1);

    in_flat = mk(7'd2, 32'hf0f0, 32'hff00, 0, 0);
    step();
    chk("and_r", out_flat[31:0], 32'hf000);
    chk("and_c", out_flat[151], 0);

    in_flat = mk(7'd3, 32'd1, 32'd0, 0, 0);
    step();
    chk("or_r", out_flat[31:0], 1);
    chk("or_p", out_flat[153], 1);

    in_flat = mk(7'd4, 32'd1, 32'd3, 0, 0);
    step();
    chk("xor_r", out_flat[31:0], 2);

    // inputs changing between edges do nothing
    snap    = out_flat;
    in_flat = mk(7'd0, 32'h77, 32'h11, 32'h5, 32'h9);
    #3;
    chk("no_edge", out_flat, snap);
    step();

    // accumulator and sticky overflow
    in_flat = mk(7'h10, 0, 0, 0, 0);
    step();
    chk("acc_clr", out_flat[63:32], 0);
    chk("ovf_clr", out_flat[152], 0);
    in_flat = mk(7'h08, 0, 0, 32'h80000000, 0);
    step();
    chk("acc_1", out_flat[63:32], 32'h80000000);
    chk("ovf_1", out_flat[152], 0);
    step();
    chk("acc_2", out_flat[63:32], 0);
    chk("ovf_2", out_flat[152], 1);
    in_flat = mk(7'h00, 0, 0, 32'h3, 0);
    step();
    chk("acc_hold", out_flat[63:32], 0);
    chk("ovf_stky", out_flat[152], 1);
    in_flat = mk(7'h08, 0, 0, 32'h5, 0);
    step();
    chk("acc_add5", out_flat[63:32], 5);
    chk("ovf_keep", out_flat[152], 1);
    in_flat = mk(7'h18, 0, 0, 32'h5, 0);
    step();
    chk("acc_cl_en", out_flat[63:32], 0);
    chk("ovf_cl_en", out_flat[152], 0);

    // rotate
    in_flat = mk(7'h20, 0, 0, 0, 32'h12345678);
    step();
    chk("rot8", out_flat[95:64], 32'h34567812);
    in_flat = mk(7'h60, 0, 0, 0, 32'h12345678);
    step();
    chk("rot24", out_flat[95:64], 32'h78123456);
    in_flat = mk(7'h00, 0, 0, 0, 32'h12345678);
    step();
    chk("rot0", out_flat[95:64], 32'h12345678);

    // two-stage C^D pipe
    in_flat = '0;
    step();
    step();
    chk("pipe_q", out_flat[127:96], 0);
    in_flat = mk(7'h00, 0, 0, 32'hffff0000, 32'h00ff00ff);
    step();
    in_flat = '0;
    chk("pipe_e1", out_flat[127:96], 0);
    step();
    chk("pipe_e2", out_flat[127:96], 32'hff0000ff);
    step();
    chk("pipe_e3", out_flat[127:96], 0);

    // popcount and echo
    in_flat = mk(7'h1f, 32'hffffffff, 0, 0, 0);
    step();
    chk("pop32", out_flat[149:144], 32);
    chk("echo1f", out_flat[158:154], 5'h1f);
    in_flat = mk(7'h65, 32'h0000000f, 0, 0, 0);
    step();
    chk("pop4", out_flat[149:144], 4);
    chk("echo05", out_flat[158:154], 5'h05);

    // async reset mid-flight
    in_flat = mk(7'h68, 32'h1, 32'h2, 32'haaaa5555, 32'h0f0f0f0f);
    step();
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_rst", out_flat, '0);
    in_flat = '0;
    step();
    chk("rst_edge", out_flat, '0);
    rst_n = 1'b0;
    step();
    chk("rel_pipe1", out_flat[127:96], 0);
    chk("rel_cnt", out_flat[143:128], 1);
    step();
    chk("rel_pipe2", out_flat[127:96], 0);
    chk("rel_acc", out_flat[63:32], 0);

    // counter wrap from zero
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", out_flat[143:128], 16'hffff);
    step();
    chk("cnt_wrap", out_flat[143:128], 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk is the clock and rst_n is the reset, active-high despite its name.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, asserted when 1.
REQ-004 SHALL have port in_flat, input, 135 bits, split into fields: A=[31:0], B=[63:32], C=[95:64], D=[127:96], CTRL=[134:128].
REQ-005 SHALL have port out_flat, output, 159 bits, driven only from registers (no combinational path from in_flat).
REQ-006 SHALL decode CTRL as: OP=CTRL[2:0], ACC_EN=CTRL[3], ACC_CLR=CTRL[4], ROT_SEL=CTRL[6:5].

Function
REQ-007 SHALL register the ALU result R into out_flat[31:0] with 1-cycle latency.
- OP 0: A+B
- OP 1: A-B
- OP 2: A&B
- OP 3: A|B
- OP 4: A^B
- OP 5: A<<B[4:0]
- OP 6: A>>B[4:0], logical
- OP 7: signed A<B gives 1, else 0
- All arithmetic modulo 2^32.
REQ-008 SHALL register CARRY into out_flat[151]:
- OP0: bit 32 of the 33-bit sum.
- OP1: 1 when A<B unsigned (borrow).
- All other OPs: 0.
REQ-009 SHALL register ZERO into out_flat[150]: 1 when the R being registered equals 0.
REQ-010 SHALL register PARITY into out_flat[153]: XOR-reduction of the R being registered.
REQ-011 SHALL update the accumulator ACC in out_flat[63:32] each cycle:
- ACC_CLR=1: ACC becomes 0, taking priority over ACC_EN.
- Else ACC_EN=1: ACC becomes ACC+C, mod 2^32.
- Otherwise ACC holds.
REQ-012 SHALL maintain sticky overflow OVF in out_flat[152]:
- Set when an ACC_EN add carries out of bit 31.
- Cleared only by ACC_CLR or reset.
- ACC_CLR with ACC_EN in the same cycle: OVF becomes 0.
REQ-013 SHALL register into out_flat[95:64] the value D rotated left by 8*ROT_SEL bits (0, 8, 16 or 24), 1-cycle latency.
REQ-014 SHALL output C^D in out_flat[127:96] through exactly two register stages (2-cycle latency).
REQ-015 SHALL run a 16-bit cycle counter in out_flat[143:128]:
- Increments by 1 every clock while reset is deasserted.
- Wraps 0xFFFF to 0x0000.
REQ-016 SHALL register popcount(A), range 0..32, into out_flat[149:144] with 1-cycle latency.
REQ-017 SHALL register CTRL[4:0] into out_flat[158:154] with 1-cycle latency.
REQ-018 SHALL sample all inputs on rising clk only; input changes between edges have no effect until the next edge.

Reset
REQ-019 SHALL, while rst_n=1, asynchronously force every register to 0, including both pipeline stages, so out_flat=0 immediately, independent of clk.
REQ-020 SHALL resume on the first rising clk after rst_n falls to 0:
- Counter reads 1 after that edge.
- The REQ-014 field stays 0 until two valid edges have occurred.
REQ-021 SHALL, when reset is asserted mid-operation, discard all in-flight pipeline data with no residual values after release.

Verification
REQ-022 Reset: rst_n=1 with arbitrary in_flat and clock running -> out_flat=0 every cycle; release rst_n=0 -> out_flat[143:128] reads 1,2,3... on successive edges.
REQ-023 ALU: A=0xFFFFFFFF, B=1, OP=0 -> next cycle R=0, ZERO=1, CARRY=1, PARITY=0. OP=1, A=0, B=1 -> R=0xFFFFFFFF, CARRY=1, PARITY=0. OP=7, A=0x80000000, B=0 -> R=1.
REQ-024 Accumulator: ACC_EN=1, C=0x80000000 for 2 cycles -> ACC=0x80000000, then 0 with OVF=1. ACC_CLR=1 together with ACC_EN=1 -> ACC=0, OVF=0.
REQ-025 Rotate/pipeline: D=0x12345678, ROT_SEL=1 -> out_flat[95:64]=0x34567812 after 1 edge. C=0xFFFF0000, D=0x00FF00FF -> out_flat[127:96]=0xFF0000FF exactly 2 edges later.
REQ-026 Popcount/echo: A=0xFFFFFFFF, CTRL=0x1F -> out_flat[149:144]=32, out_flat[158:154]=0x1F. Counter run 65536 cycles from 0 -> wraps to 0.
